// File: rtl/inst_fetch_unit.sv
// Instruction fetch: registered PC with sequential/jump next-PC select feeding a word-addressed instruction memory.
// Latency: pc updates on the rising clk edge; pc_4, instruction and debug_out are combinational (zero cycles).
// Backpressure: none; the PC advances every cycle and memory writes are accepted on any cycle out of reset.
// Optional feature: define INST_FETCH_DEBUG_EN to enable the debug read port (otherwise debug_out is tied to zero).
module inst_fetch_unit #(
    parameter int unsigned IMEM_WORDS = 512
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_sel,
    input  logic [31:0] jump_addr,
    input  logic        write_en,
    input  logic [31:0] write_addr,
    input  logic [31:0] write_data,
    input  logic        debug_en,
    input  logic [31:0] debug_pc,
    output logic [31:0] pc,
    output logic [31:0] pc_4,
    output logic [31:0] instruction,
    output logic [31:0] debug_out
);

    // Word-index width; byte addresses use bits [AW+1:2], so memory aliases every 4*IMEM_WORDS bytes.
    localparam int unsigned AW = $clog2(IMEM_WORDS);

    // Storage powers up as all zeros and is deliberately outside the reset domain,
    // so a reset pulse mid-run leaves the loaded program intact.
    logic [31:0] mem [IMEM_WORDS] = '{default: 32'h0000_0000};

    logic [AW-1:0] fetch_idx;
    logic [AW-1:0] write_idx;
    logic [31:0]   next_pc;

    // Byte lanes [1:0] and the bits above the memory span never take part in indexing.
    assign fetch_idx = pc[AW+1:2];
    assign write_idx = write_addr[AW+1:2];

    // Sequential address wraps naturally at 2^32 through the 32-bit add.
    assign pc_4 = pc + 32'd4;

    // jump_addr is taken verbatim, including bits [1:0]; only indexing drops them.
    assign next_pc = pc_sel ? jump_addr : pc_4;

    // PC register: cleared asynchronously, otherwise loads the selected next PC every edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc <= 32'h0000_0000;
        end else begin
            pc <= next_pc;
        end
    end

    // Memory write port: full-word writes, suppressed while reset is held low.
    always_ff @(posedge clk) begin
        if (write_en && reset) begin
            mem[write_idx] <= write_data;
        end
    end

    // Asynchronous fetch read, so a write to the current word is visible right after its edge.
    assign instruction = mem[fetch_idx];

`ifdef INST_FETCH_DEBUG_EN
    logic [AW-1:0] debug_idx;
    assign debug_idx = debug_pc[AW+1:2];

    // Debug read port: second asynchronous read, forced to zero when not enabled.
    assign debug_out = debug_en ? mem[debug_idx] : 32'h0000_0000;

    // Address bits outside the indexed span are intentionally dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{write_addr[31:AW+2], write_addr[1:0],
                                debug_pc[31:AW+2], debug_pc[1:0]};
`else
    // Debug port present but inert in this build.
    assign debug_out = 32'h0000_0000;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{write_addr[31:AW+2], write_addr[1:0],
                                debug_pc, debug_en};
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: reset, jump, load/readback, alias/wrap, write-through and debug port.
// Latency: expectations are queued when a fetch edge is driven and compared one step after that edge.
// Backpressure: none; a watchdog bounds the run and reports a failure if it expires.
module tb_inst_fetch_unit;

    localparam int unsigned WORDS = 512;

    logic        clk;
    logic        reset;
    logic        pc_sel;
    logic [31:0] jump_addr;
    logic        write_en;
    logic [31:0] write_addr;
    logic [31:0] write_data;
    logic        debug_en;
    logic [31:0] debug_pc;
    logic [31:0] pc;
    logic [31:0] pc_4;
    logic [31:0] instruction;
    logic [31:0] debug_out;

    typedef struct packed {
        logic [31:0] exp_pc;
        logic [31:0] exp_pc_4;
        logic [31:0] exp_instr;
    } fetch_exp_t;

    fetch_exp_t  sb_q[$];
    logic [31:0] model_mem [WORDS];
    logic [31:0] model_pc;
    int          checks_done;
    int          errors_seen;

    inst_fetch_unit #(.IMEM_WORDS(WORDS)) dut (
        .clk         (clk),
        .reset       (reset),
        .pc_sel      (pc_sel),
        .jump_addr   (jump_addr),
        .write_en    (write_en),
        .write_addr  (write_addr),
        .write_data  (write_data),
        .debug_en    (debug_en),
        .debug_pc    (debug_pc),
        .pc          (pc),
        .pc_4        (pc_4),
        .instruction (instruction),
        .debug_out   (debug_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_done++;
        if (got !== exp) begin
            errors_seen++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_rd(input logic [31:0] addr);
        return model_mem[addr[10:2]];
    endfunction

    // One fetch edge: predict next PC from the model, queue the expectation, clock, then compare.
    task automatic fetch_step(input logic sel, input logic [31:0] jaddr, input string tag);
        fetch_exp_t e;
        fetch_exp_t got_e;
        pc_sel    = sel;
        jump_addr = jaddr;
        model_pc  = sel ? jaddr : model_pc + 32'd4;
        e.exp_pc    = model_pc;
        e.exp_pc_4  = model_pc + 32'd4;
        e.exp_instr = model_rd(model_pc);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check_val({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            got_e = sb_q.pop_front();
            check_val({tag, "_pc"}, pc, got_e.exp_pc);
            check_val({tag, "_pc4"}, pc_4, got_e.exp_pc_4);
            check_val({tag, "_instr"}, instruction, got_e.exp_instr);
        end
    endtask

    // Check combinational fetch outputs against the model at the current PC.
    task automatic check_now(input string tag);
        check_val({tag, "_pc"}, pc, model_pc);
        check_val({tag, "_pc4"}, pc_4, model_pc + 32'd4);
        check_val({tag, "_instr"}, instruction, model_rd(model_pc));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        errors_seen++;
        $display("Simulation finished: %0d checks, %0d errors", checks_done, errors_seen);
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks_done = 0;
        errors_seen = 0;
        for (int i = 0; i < WORDS; i++) model_mem[i] = 32'h0;
        model_pc   = 32'h0;
        reset      = 1'b0;
        pc_sel     = 1'b0;
        jump_addr  = 32'h0;
        write_en   = 1'b0;
        write_addr = 32'h0;
        write_data = 32'h0;
        debug_en   = 1'b0;
        debug_pc   = 32'h0;

        // Reset state, memory powered up as zero.
        repeat (2) @(posedge clk);
        #1;
        check_now("reset_hold");
        check_val("reset_debug", debug_out, 32'h0);

        // Release and advance two sequential edges.
        reset = 1'b1;
        fetch_step(1'b0, 32'h0, "seq1");
        fetch_step(1'b0, 32'h0, "seq2");

        // Load word 1, then assert reset mid-cycle: pc clears before the next edge.
        write_en = 1'b1; write_addr = 32'h4; write_data = 32'hDEAD_BEEF;
        model_mem[1] = 32'hDEAD_BEEF;
        fetch_step(1'b0, 32'h0, "pre_rst");
        write_en = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        model_pc = 32'h0;
        check_val("async_rst_pc", pc, 32'h0);
        check_val("async_rst_pc4", pc_4, 32'h4);

        // Write attempt under reset must be dropped; memory keeps its contents.
        write_en = 1'b1; write_addr = 32'h8; write_data = 32'h1234_5678;
        @(posedge clk);
        #1;
        write_en = 1'b0;
        check_val("rst_hold_pc", pc, 32'h0);
        reset = 1'b1;
        fetch_step(1'b0, 32'h0, "mem_kept");
        fetch_step(1'b0, 32'h0, "wr_blocked");

        // Jump then continue sequentially.
        fetch_step(1'b1, 32'h100, "jump");
        fetch_step(1'b0, 32'h0, "post_jump");

        // Write to the word at pc while holding pc: old value before the edge, new after.
        check_val("wt_before", instruction, 32'h0);
        write_en = 1'b1; write_addr = 32'h104; write_data = 32'hCAFE_0104;
        model_mem[32'h104 >> 2] = 32'hCAFE_0104;
        fetch_step(1'b1, 32'h104, "wt_after");
        write_en = 1'b0;

        // Bulk load with junk in the byte-lane bits of the address; pc runs freely meanwhile.
        for (int i = 0; i < WORDS; i++) begin
            write_en   = 1'b1;
            write_addr = (i * 4) | (i & 3);
            write_data = 32'hA500_0000 + i;
            model_mem[i] = 32'hA500_0000 + i;
            @(posedge clk);
            #1;
        end
        write_en = 1'b0;
        model_pc = pc;

        // Readback: jump to 0, then walk every word; the last step lands on 0x800 (aliases word 0).
        fetch_step(1'b1, 32'h0, "rb_jump0");
        for (int i = 1; i <= WORDS; i++) begin
            fetch_step(1'b0, 32'h0, "readback");
        end
        check_val("alias_800_pc", pc, 32'h800);
        check_val("alias_800", instruction, 32'hA500_0000);

        // Unaligned jump target kept verbatim, low bits ignored for fetch.
        fetch_step(1'b1, 32'h12, "unaligned");

        // Top-of-space wrap.
        fetch_step(1'b1, 32'hFFFF_FFFC, "wrap_top");
        check_val("wrap_pc4", pc_4, 32'h0);
        fetch_step(1'b0, 32'h0, "wrap_zero");

        // Simultaneous write and jump to the written word.
        write_en = 1'b1; write_addr = 32'h20; write_data = 32'h5A5A_0020;
        model_mem[8] = 32'h5A5A_0020;
        fetch_step(1'b1, 32'h20, "wr_and_jump");
        write_en = 1'b0;

        // Debug port.
        debug_en = 1'b1; debug_pc = 32'h10;
        #1;
`ifdef INST_FETCH_DEBUG_EN
        check_val("debug_on", debug_out, model_mem[4]);
        debug_pc = 32'h20;
        #1;
        check_val("debug_on2", debug_out, model_mem[8]);
`else
        check_val("debug_off_build", debug_out, 32'h0);
`endif
        debug_en = 1'b0;
        #1;
        check_val("debug_dis", debug_out, 32'h0);

        check_val("sb_drained", sb_q.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks_done, errors_seen);
        $finish;
    end

endmodule
